// File: rtl/led_pattern_seq.sv
// Multi-channel LED pattern sequencer.
// A prescaled frame counter walks through up to SEGMENTS programmable segments.
// Each channel outputs its programmed level for the active segment.
// Configuration is captured into shadow registers at start and at each loop wrap,
// so the frame in progress never sees a config change.
module led_pattern_seq #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SEGMENTS = 6,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned PRESC_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         pause,
   input  logic                         loop,
   input  logic [PRESC_W-1:0]           prescale,
   input  logic [CNT_W-1:0]             period,
   input  logic [SEGMENTS*CNT_W-1:0]    seg_end,
   input  logic [CHANNELS*SEGMENTS-1:0] pattern,
   output logic [CHANNELS-1:0]          led,
   output logic                         busy,
   output logic                         wrap,
   output logic                         done
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [PRESC_W-1:0]          presc_q, presc_d;
   logic [CHANNELS-1:0]         led_q, led_d;
   logic                        wrap_q, wrap_d;
   logic                        done_q, done_d;

   // Shadowed configuration
   logic [PRESC_W-1:0]          prescale_q;
   logic [CNT_W-1:0]            period_q;
   logic [SEGMENTS*CNT_W-1:0]   seg_end_q;
   logic [CHANNELS*SEGMENTS-1:0] pattern_q;
   logic                        loop_q;
   logic                        load_cfg;

   logic [CHANNELS-1:0]         level;
   logic                        hit;

   // Segment decode: the first boundary above the counter selects the segment
   always_comb begin
      level = '0;
      hit   = 1'b0;
      for (int i = 0; i < SEGMENTS; i++) begin
         if (!hit && (cnt_q < seg_end_q[i*CNT_W +: CNT_W])) begin
            hit = 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
               level[c] = pattern_q[c*SEGMENTS + i];
            end
         end
      end
   end

   // Next-state logic: control FSM, prescaler, frame counter and pulses
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      presc_d  = presc_q;
      led_d    = led_q;
      wrap_d   = 1'b0;
      done_d   = 1'b0;
      load_cfg = 1'b0;
      unique case (state_q)
         StIdle: begin
            led_d = '0;
            if (start && !stop) begin
               state_d  = StRun;
               cnt_d    = '0;
               presc_d  = '0;
               load_cfg = 1'b1;
            end
         end
         StRun: begin
            // led follows the counter one clock late; it freezes with the counter
            if (!pause) begin
               led_d = level;
            end
            if (stop) begin
               state_d = StIdle;
            end else if (!pause) begin
               if (presc_q == prescale_q) begin
                  presc_d = '0;
                  if (cnt_q == period_q) begin
                     cnt_d = '0;
                     if (loop_q) begin
                        wrap_d   = 1'b1;
                        load_cfg = 1'b1;
                     end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  presc_d = presc_q + PRESC_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         presc_q <= '0;
         led_q   <= '0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         led_q   <= led_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   // Config shadows, captured at start and at each loop wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q <= '0;
         period_q   <= '0;
         seg_end_q  <= '0;
         pattern_q  <= '0;
         loop_q     <= 1'b0;
      end else if (load_cfg) begin
         prescale_q <= prescale;
         period_q   <= period;
         seg_end_q  <= seg_end;
         pattern_q  <= pattern;
         loop_q     <= loop;
      end
   end

   assign led  = led_q;
   assign busy = (state_q == StRun);
   assign wrap = wrap_q;
   assign done = done_q;

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Parametrised multi-channel LED pattern sequencer. A free-running frame counter, advanced by a programmable prescaler, is split into up to SEGMENTS programmable segments. Each channel drives a per-segment level. The block adds loop/one-shot modes, start/stop/pause control, frame-boundary config shadowing and status pulses. It sits between board-level control logic and the LED pins.

Parameters:
CHANNELS, 4, number of LED outputs.
SEGMENTS, 6, number of segments per frame.
CNT_W, 8, frame counter and segment boundary width.
PRESC_W, 16, prescaler width.

Ports:
clk  input  1  system clock; single clock domain.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a frame sequence.
stop  input  1  one-cycle request to abort to IDLE.
pause  input  1  level; when high in RUN, counter and prescaler freeze.
loop  input  1  1 = repeat frames, 0 = one-shot; sampled at start and at each wrap.
prescale  input  PRESC_W  tick every prescale+1 clk cycles.
period  input  CNT_W  last counter value in a frame; frame = period+1 ticks.
seg_end  input  SEGMENTS*CNT_W  exclusive upper bound of segment i in bits [i*CNT_W +: CNT_W].
pattern  input  CHANNELS*SEGMENTS  level of channel c in segment i at bit c*SEGMENTS+i.
led  output  CHANNELS  registered LED levels.
busy  output  1  high while in RUN.
wrap  output  1  one-cycle pulse when the counter wraps in loop mode.
done  output  1  one-cycle pulse when a one-shot frame completes.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. It clears all state to zero: FSM=IDLE, counter, prescaler, shadows. Outputs led=0, busy=0, wrap=0, done=0. Reset asserted mid-frame forces these values immediately, without waiting for a clk edge.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on start with stop low. On that edge: counter=0, presc_cnt=0, and period, seg_end, pattern and loop load into shadow registers.
  - RUN -> IDLE on stop. stop takes priority over start and over a wrap on the same edge.
  - start while in RUN is ignored.
- Prescaler, RUN and pause low only:
  - tick = (presc_cnt == prescale_shadow). On tick, presc_cnt <= 0; otherwise it increments.
  - prescale=0 gives a tick every cycle. prescale is shadowed with the other config.
- Counter, advances on tick only:
  - If counter == period_shadow, the frame ends. Loop mode: counter <= 0, shadows reload, wrap=1 for one cycle. One-shot mode: done=1 for one cycle, FSM -> IDLE, counter <= 0.
  - Otherwise counter <= counter+1.
  - period=0: every tick ends a frame.
- Pause high in RUN: counter, presc_cnt and led hold; busy stays 1. Pulses are not generated while paused.
- Segment decode (combinational from counter and shadows):
  - seg = smallest i with counter < seg_end[i]. If none matches, there is no segment and all channels decode to 0.
  - Boundaries are compared unsigned. They need not be monotonic; the first match wins.
- led[c] <= pattern_shadow[c*SEGMENTS+seg] while in RUN, else 0. Registered: led lags the counter by exactly one clk.
- Config changes on inputs while in RUN take effect only at the next wrap or start. The current frame is never glitched.
- busy = (state == RUN), registered with the state.
- wrap and done are registered and never high together.

Test Plan:
1. Reset mid-run: drive rst_n low while counter=37 and led=1 -> led=0, busy=0 immediately. After release, the block stays in IDLE until start.
2. Base pattern: period=150, prescale=0, seg_end={20,30,60,90,140,151}, ch0 pattern 1,0,1,0,1,0, loop=1, start at edge T -> led[0]=1 from T+1..T+20, 0 T+21..T+30, 1 T+31..T+60, 0 T+61..T+90, 1 T+91..T+140, 0 T+141..T+151. wrap pulses at T+151; the pattern repeats with period 151 cycles.
3. Prescaler and pause: prescale=3, period=4 -> counter steps every 4 clk; wrap every 20 clk. pause for 7 cycles mid-frame extends that frame to 27 clk; led holds throughout.
4. One-shot: loop=0, period=9, prescale=0 -> done single pulse 10 clk after start; busy falls on the same edge; led=0 next cycle; no wrap pulse.
5. Shadowing: change pattern and period mid-frame -> old values persist until wrap; new values are visible from the first post-wrap cycle. With stop and start asserted together in RUN -> IDLE, led=0.
6. Multi-channel and no-segment gap: CHANNELS=4 with distinct patterns, seg_end[5]=100, period=150 -> all channels 0 for counter 100..150. Each channel matches its pattern bits exactly otherwise.
